// File: rtl/decim_rate_scheduler.sv
// Clock-enable scheduler for a cascade of decimation stages: divides ce_in into NS nested
// rate strobes, with runtime division ratios swapped atomically at the frame boundary.
module decim_rate_scheduler #(
  parameter int NS = 3,
  parameter int CW = 10,
  parameter logic [NS*CW-1:0] DEFAULT_TOP = {NS{10'd1}}
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic           ce_in,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [NS*CW-1:0] cfg_top,
  output logic [NS-1:0]  ce_out,
  output logic           frame_sync,
  output logic           cfg_pending
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        state_r, state_n;
  logic [CW-1:0] active_r [NS];
  logic [CW-1:0] active_n [NS];
  logic [CW-1:0] pend_top_r [NS];
  logic [CW-1:0] cnt_r [NS];
  logic [CW-1:0] cnt_n [NS];
  logic          pend_r, pend_n;
  logic          ready_r;
  logic [NS-1:0] ce_out_r;
  logic          frame_r;
  logic [NS-1:0] adv_s, zero_s, wrap_s;
  logic          run_s, xfer_s, apply_s;

  // Stopping the FSM gates the whole carry chain, so no strobe is generated on the exit cycle.
  assign run_s  = (state_r == RUN) & enable;
  assign xfer_s = cfg_valid & ready_r;

  // Ripple carry: a stage advances only when every faster stage is wrapping.
  always_comb begin
    logic carry_v;
    carry_v = run_s & ce_in;
    adv_s   = '0;
    zero_s  = '0;
    wrap_s  = '0;
    for (int k = 0; k < NS; k++) begin
      zero_s[k] = (cnt_r[k] == '0);
      adv_s[k]  = carry_v;
      wrap_s[k] = carry_v & zero_s[k];
      carry_v   = carry_v & zero_s[k];
    end
  end

  // FSM next state, counter reload/decrement and pending-config apply.
  always_comb begin
    state_n = state_r;
    apply_s = 1'b0;
    for (int k = 0; k < NS; k++) begin
      active_n[k] = active_r[k];
      cnt_n[k]    = cnt_r[k];
    end
    case (state_r)
      IDLE: begin
        if (enable) state_n = RUN;
        else        state_n = IDLE;
        if (pend_r) begin
          apply_s = 1'b1;
          for (int k = 0; k < NS; k++) begin
            active_n[k] = pend_top_r[k];
            cnt_n[k]    = pend_top_r[k];
          end
        end else begin
          apply_s = 1'b0;
        end
      end
      RUN: begin
        if (!enable) begin
          state_n = IDLE;
          for (int k = 0; k < NS; k++) cnt_n[k] = active_r[k];
        end else begin
          // At the boundary every stage is reloading, so all of them take the new TOP together.
          apply_s = wrap_s[NS-1] & pend_r;
          for (int k = 0; k < NS; k++) begin
            if (adv_s[k]) begin
              if (zero_s[k]) cnt_n[k] = apply_s ? pend_top_r[k] : active_r[k];
              else           cnt_n[k] = cnt_r[k] - CNT_ONE;
            end else begin
              cnt_n[k] = cnt_r[k];
            end
            if (apply_s) active_n[k] = pend_top_r[k];
            else         active_n[k] = active_r[k];
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // A transfer needs pend=0 and an apply needs pend=1, so the two never collide.
    if (apply_s)     pend_n = 1'b0;
    else if (xfer_s) pend_n = 1'b1;
    else             pend_n = pend_r;
  end

  // State, counters and registered strobe outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      pend_r   <= 1'b0;
      ready_r  <= 1'b1;
      ce_out_r <= '0;
      frame_r  <= 1'b0;
      for (int k = 0; k < NS; k++) begin
        active_r[k] <= DEFAULT_TOP[k*CW +: CW];
        cnt_r[k]    <= DEFAULT_TOP[k*CW +: CW];
      end
    end else begin
      state_r  <= state_n;
      pend_r   <= pend_n;
      ready_r  <= ~pend_n;
      ce_out_r <= wrap_s;
      frame_r  <= wrap_s[NS-1];
      for (int k = 0; k < NS; k++) begin
        active_r[k] <= active_n[k];
        cnt_r[k]    <= cnt_n[k];
      end
    end
  end

  // Pending configuration capture on a handshake transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NS; k++) pend_top_r[k] <= DEFAULT_TOP[k*CW +: CW];
    end else if (xfer_s) begin
      for (int k = 0; k < NS; k++) pend_top_r[k] <= cfg_top[k*CW +: CW];
    end else begin
      for (int k = 0; k < NS; k++) pend_top_r[k] <= pend_top_r[k];
    end
  end

  assign ce_out      = ce_out_r;
  assign frame_sync  = frame_r;
  assign cfg_ready   = ready_r;
  assign cfg_pending = pend_r;

endmodule

// File: tb/tb_decim_rate_scheduler.sv
// Self-checking bench for decim_rate_scheduler: per-cycle scoreboard against an up-counting
// reference model, plus directed rate/boundary checks per scenario.
module tb_decim_rate_scheduler;
  localparam int NS = 3;
  localparam int CW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1, enable = 1'b0, ce_in = 1'b0, cfg_valid = 1'b0;
  logic [NS*CW-1:0] cfg_top = '0;
  logic cfg_ready, frame_sync, cfg_pending;
  logic [NS-1:0] ce_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [NS-1:0] ce;
    logic          fs;
    logic          rdy;
    logic          pnd;
  } exp_t;
  exp_t sb_q[$];

  // Reference model: up-counters counting strobes received since the last wrap.
  bit m_run = 1'b0;
  bit m_pend = 1'b0;
  int m_act[NS];
  int m_up[NS];
  int m_ptop[NS];

  localparam logic [NS*CW-1:0] TOP_A = {10'd2, 10'd0, 10'd4};
  localparam logic [NS*CW-1:0] TOP_B = {10'd0, 10'd1, 10'd2};
  localparam logic [NS*CW-1:0] TOP_C = {10'd0, 10'd0, 10'd3};
  localparam logic [NS*CW-1:0] TOP_X = {10'd5, 10'd5, 10'd5};
  localparam logic [NS*CW-1:0] TOP_D = {10'd1, 10'd2, 10'd6};
  localparam logic [NS*CW-1:0] TOP_E = {10'd3, 10'd3, 10'd3};

  always #5 clk = ~clk;

  decim_rate_scheduler #(.NS(NS), .CW(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ce_in(ce_in),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_top(cfg_top),
    .ce_out(ce_out), .frame_sync(frame_sync), .cfg_pending(cfg_pending)
  );

  task automatic model_step(input logic r, en, ce, cv, input logic [NS*CW-1:0] top);
    exp_t e;
    bit xfer, carry;
    logic [NS-1:0] w;
    w = '0;
    if (r) begin
      m_run = 1'b0;
      m_pend = 1'b0;
      for (int k = 0; k < NS; k++) begin m_act[k] = 1; m_up[k] = 0; end
    end else begin
      xfer = cv && !m_pend;
      if (!m_run) begin
        if (m_pend) begin
          for (int k = 0; k < NS; k++) begin m_act[k] = m_ptop[k]; m_up[k] = 0; end
          m_pend = 1'b0;
        end
        m_run = en;
      end else if (!en) begin
        for (int k = 0; k < NS; k++) m_up[k] = 0;
        m_run = 1'b0;
      end else begin
        carry = ce;
        for (int k = 0; k < NS; k++) begin
          if (carry) begin
            if (m_up[k] == m_act[k]) begin w[k] = 1'b1; m_up[k] = 0; end
            else begin m_up[k]++; carry = 1'b0; end
          end
        end
        if (w[NS-1] && m_pend) begin
          for (int k = 0; k < NS; k++) m_act[k] = m_ptop[k];
          m_pend = 1'b0;
        end
      end
      if (xfer) begin
        for (int k = 0; k < NS; k++) m_ptop[k] = int'(top[k*CW +: CW]);
        m_pend = 1'b1;
      end
    end
    e.ce = w; e.fs = w[NS-1]; e.rdy = !m_pend; e.pnd = m_pend;
    sb_q.push_back(e);
  endtask

  function automatic bit m_boundary();
    bit b;
    b = m_run;
    for (int k = 0; k < NS; k++) if (m_up[k] != m_act[k]) b = 1'b0;
    return b;
  endfunction

  task automatic tick(input logic r, en, ce, cv, input logic [NS*CW-1:0] top);
    @(negedge clk);
    rst = r; enable = en; ce_in = ce; cfg_valid = cv; cfg_top = top;
    model_step(r, en, ce, cv, top);
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: compare every registered output against the model one cycle after stimulus.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (ce_out !== e.ce || frame_sync !== e.fs || cfg_ready !== e.rdy || cfg_pending !== e.pnd) begin
        errors++;
        $display("FAIL scoreboard t=%0t ce_out=%b exp %b frame_sync=%b exp %b cfg_ready=%b exp %b cfg_pending=%b exp %b",
                 $time, ce_out, e.ce, frame_sync, e.fs, cfg_ready, e.rdy, cfg_pending, e.pnd);
      end
    end
  end

  task automatic test_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
    checks++;
    if ({ce_out, frame_sync, cfg_ready, cfg_pending} !== {3'b000, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got ce=%b fs=%b rdy=%b pnd=%b expected 000 0 1 0", ce_out, frame_sync, cfg_ready, cfg_pending);
    end
  endtask

  task automatic test_defaults();
    int first0 = -1, first2 = -1, n0 = 0, n1 = 0, n2 = 0, nf = 0;
    tick(1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 32; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0, '0);
      if (ce_out[0] === 1'b1) begin n0++; if (first0 < 0) first0 = i; end
      if (ce_out[1] === 1'b1) n1++;
      if (ce_out[2] === 1'b1) begin n2++; if (first2 < 0) first2 = i; end
      if (frame_sync === 1'b1) nf++;
    end
    checks++; if (first0 !== 1)  begin errors++; $display("FAIL defaults_first_ce0: got %0d expected 1", first0); end
    checks++; if (first2 !== 7)  begin errors++; $display("FAIL defaults_first_ce2: got %0d expected 7", first2); end
    checks++; if (n0 !== 16) begin errors++; $display("FAIL defaults_count_ce0: got %0d expected 16", n0); end
    checks++; if (n1 !== 8)  begin errors++; $display("FAIL defaults_count_ce1: got %0d expected 8", n1); end
    checks++; if (n2 !== 4)  begin errors++; $display("FAIL defaults_count_ce2: got %0d expected 4", n2); end
    checks++; if (nf !== 4)  begin errors++; $display("FAIL defaults_count_fs: got %0d expected 4", nf); end
  endtask

  task automatic test_new_config();
    int idx = 0, last0 = -1, last2, bidx = -1, neq = 0;
    for (int i = 0; i < 9; i++) begin
      tick(1'b0, 1'b1, logic'(idx % 3 == 0), 1'b0, '0);
      idx++;
    end
    tick(1'b0, 1'b1, logic'(idx % 3 == 0), 1'b1, TOP_A);
    idx++;
    checks++;
    if (cfg_ready !== 1'b0 || cfg_pending !== 1'b1) begin
      errors++; $display("FAIL newcfg_accept: got rdy=%b pnd=%b expected 0 1", cfg_ready, cfg_pending);
    end
    for (int i = 0; i < 60 && bidx < 0; i++) begin
      tick(1'b0, 1'b1, logic'(idx % 3 == 0), 1'b0, '0);
      if (ce_out[0] === 1'b1) begin
        if (last0 >= 0) begin
          checks++;
          if (idx - last0 !== 6) begin errors++; $display("FAIL newcfg_old_rate: got %0d expected 6", idx - last0); end
        end
        last0 = idx;
      end
      if (frame_sync === 1'b1) begin
        bidx = idx;
        checks++;
        if (cfg_pending !== 1'b0) begin errors++; $display("FAIL newcfg_pending_clear: got %b expected 0", cfg_pending); end
      end
      idx++;
    end
    checks++;
    if (bidx < 0) begin errors++; $display("FAIL newcfg_boundary_timeout: got none expected frame_sync"); return; end
    last0 = bidx; last2 = bidx;
    for (int i = 0; i < 90; i++) begin
      tick(1'b0, 1'b1, logic'(idx % 3 == 0), 1'b0, '0);
      if (ce_out[1] !== ce_out[0]) neq++;
      if (ce_out[0] === 1'b1) begin
        checks++;
        if (idx - last0 !== 15) begin errors++; $display("FAIL newcfg_ce0_period: got %0d expected 15", idx - last0); end
        last0 = idx;
      end
      if (ce_out[2] === 1'b1) begin
        checks++;
        if (idx - last2 !== 45) begin errors++; $display("FAIL newcfg_ce2_period: got %0d expected 45", idx - last2); end
        last2 = idx;
      end
      idx++;
    end
    checks++; if (neq !== 0) begin errors++; $display("FAIL newcfg_ce1_eq_ce0: got %0d differing cycles expected 0", neq); end
    checks++; if (idx - 1 - last2 !== 0) begin errors++; $display("FAIL newcfg_last_ce2: got offset %0d expected 0", idx - 1 - last2); end
  endtask

  task automatic test_boundary_xfer();
    int fs_idx[$];
    bit sent = 1'b0;
    for (int i = 0; i < 80 && fs_idx.size() < 3; i++) begin
      bit b;
      b = !sent && !m_pend && m_boundary();
      tick(1'b0, 1'b1, 1'b1, b, TOP_B);
      if (b) begin
        sent = 1'b1;
        checks++;
        if (frame_sync !== 1'b1 || cfg_pending !== 1'b1) begin
          errors++; $display("FAIL bxfer_accept: got fs=%b pnd=%b expected 1 1", frame_sync, cfg_pending);
        end
      end
      if (sent && frame_sync === 1'b1) begin
        fs_idx.push_back(i);
        if (fs_idx.size() == 2) begin
          checks++;
          if (cfg_pending !== 1'b0) begin errors++; $display("FAIL bxfer_apply: got pnd=%b expected 0", cfg_pending); end
        end
      end
    end
    checks++;
    if (fs_idx.size() != 3) begin errors++; $display("FAIL bxfer_timeout: got %0d frames expected 3", fs_idx.size()); return; end
    checks++; if (fs_idx[1] - fs_idx[0] !== 15) begin errors++; $display("FAIL bxfer_old_frame: got %0d expected 15", fs_idx[1] - fs_idx[0]); end
    checks++; if (fs_idx[2] - fs_idx[1] !== 6)  begin errors++; $display("FAIL bxfer_new_frame: got %0d expected 6", fs_idx[2] - fs_idx[1]); end
  endtask

  task automatic test_second_cfg();
    int fs_idx[$];
    tick(1'b0, 1'b1, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, TOP_C);
    tick(1'b0, 1'b1, 1'b0, 1'b1, TOP_X);
    checks++;
    if (cfg_ready !== 1'b0 || cfg_pending !== 1'b1) begin
      errors++; $display("FAIL second_cfg_blocked: got rdy=%b pnd=%b expected 0 1", cfg_ready, cfg_pending);
    end
    for (int i = 0; i < 30 && fs_idx.size() < 3; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0, '0);
      if (frame_sync === 1'b1) fs_idx.push_back(i);
    end
    checks++;
    if (fs_idx.size() != 3) begin errors++; $display("FAIL second_cfg_timeout: got %0d frames expected 3", fs_idx.size()); return; end
    checks++; if (fs_idx[0] !== 3) begin errors++; $display("FAIL second_cfg_first_fs: got %0d expected 3", fs_idx[0]); end
    checks++; if (fs_idx[2] - fs_idx[1] !== 4) begin errors++; $display("FAIL second_cfg_frame: got %0d expected 4", fs_idx[2] - fs_idx[1]); end
  endtask

  task automatic test_disable();
    int first0 = -1;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, TOP_D);
    tick(1'b0, 1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (ce_out !== 3'b000 || frame_sync !== 1'b0 || cfg_pending !== 1'b1) begin
      errors++; $display("FAIL disable_outputs: got ce=%b fs=%b pnd=%b expected 000 0 1", ce_out, frame_sync, cfg_pending);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (cfg_pending !== 1'b0 || cfg_ready !== 1'b1 || ce_out !== 3'b000) begin
      errors++; $display("FAIL disable_idle_apply: got pnd=%b rdy=%b ce=%b expected 0 1 000", cfg_pending, cfg_ready, ce_out);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 20 && first0 < 0; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0, '0);
      if (ce_out[0] === 1'b1) first0 = i;
    end
    checks++; if (first0 !== 6) begin errors++; $display("FAIL reenable_first_ce0: got %0d expected 6", first0); end
  endtask

  task automatic test_reset_mid();
    int first0 = -1, first2 = -1;
    tick(1'b0, 1'b1, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, TOP_E);
    checks++; if (cfg_pending !== 1'b1) begin errors++; $display("FAIL rstmid_pending: got %b expected 1", cfg_pending); end
    tick(1'b1, 1'b1, 1'b1, 1'b0, '0);
    checks++;
    if ({ce_out, frame_sync, cfg_ready, cfg_pending} !== {3'b000, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL rstmid_state: got ce=%b fs=%b rdy=%b pnd=%b expected 000 0 1 0", ce_out, frame_sync, cfg_ready, cfg_pending);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0, '0);
      if (ce_out[0] === 1'b1 && first0 < 0) first0 = i;
      if (ce_out[2] === 1'b1 && first2 < 0) first2 = i;
    end
    checks++; if (first0 !== 1) begin errors++; $display("FAIL rstmid_first_ce0: got %0d expected 1", first0); end
    checks++; if (first2 !== 7) begin errors++; $display("FAIL rstmid_first_ce2: got %0d expected 7", first2); end
  endtask

  initial begin
    for (int k = 0; k < NS; k++) begin m_act[k] = 1; m_up[k] = 0; m_ptop[k] = 1; end
    test_reset();
    test_defaults();
    test_new_config();
    test_boundary_xfer();
    test_second_cfg();
    test_disable();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decim_rate_scheduler.md
Name: decim_rate_scheduler

Overview:
Central clock-enable scheduler for a cascade of decimation stages. It divides an input sample strobe into NS nested rate strobes, each a programmable integer division of the previous one, so downstream decimator and filter stages all run from one coherent timebase. Runtime division ratios arrive over a valid/ready config port. They are applied atomically at a frame boundary, where all stages wrap together, so rates never glitch mid-frame.

Parameters:
NS, 3, number of cascaded rate stages (1..8)
CW, 10, width of each per-stage TOP/counter
DEFAULT_TOP, {NS{10'd1}} (NS*CW bits), reset division config; stage k occupies bits [k*CW +: CW]

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  run scheduler; low = idle, no strobes
ce_in  in  1  input sample strobe, single-cycle pulses
cfg_valid  in  1  new config offered
cfg_ready  out  1  config can be accepted (no pending config)
cfg_top  in  NS*CW  per-stage TOP; stage k divides its input by TOP_k+1
ce_out  out  NS  per-stage output strobes; ce_out[k] rate = f_ce_in / prod_{j<=k}(TOP_j+1)
frame_sync  out  1  pulse on frame boundary (stage NS-1 wrap)
cfg_pending  out  1  accepted config awaiting boundary

Behaviour:
- State: active_top[NS] (applied), pend_top[NS], pend flag, cnt[NS] (CW bits each), FSM {IDLE, RUN}.
- Reset (rst=1 at posedge): FSM=IDLE; active_top=DEFAULT_TOP; cnt[k]=DEFAULT_TOP_k; pend=0; ce_out=0; frame_sync=0; cfg_ready=1. Reset mid-operation discards any pending config.
- Carry chain, all combinational within one cycle, RUN only:
  - adv_0 = ce_in
  - adv_k = adv_{k-1} & (cnt[k-1]==0)
  - wrap_k = adv_k & (cnt[k]==0)
- Counter update on adv_k: if cnt[k]==0, reload active_top[k]; else cnt[k]-1. No adv_k: hold.
- Outputs are registered with 1-cycle latency: ce_out[k] <= wrap_k; frame_sync <= wrap_{NS-1}. Every strobe is a single-cycle pulse. All ce_out bits that wrap on the same ce_in pulse assert in the same cycle.
- Division: stage k emits one strobe per TOP_k+1 strobes of stage k-1. TOP=0 means pass-through (wrap on every adv). First ce_out[0] occurs on the (TOP_0+1)th ce_in after entering RUN.
- Config handshake:
  - Transfer occurs when cfg_valid & cfg_ready.
  - cfg_ready = ~pend.
  - On transfer, pend_top<=cfg_top and pend<=1. cfg_top is don't-care otherwise.
- Config apply:
  - IDLE: pending config applies on the next cycle: active_top<=pend_top, cnt<=pend_top, pend<=0.
  - RUN: applies only on a cycle with wrap_{NS-1}=1. In that cycle, every cnt[k] that would reload loads pend_top[k] instead of the old TOP, and active_top<=pend_top, pend<=0.
  - Simultaneous transfer and boundary in the same cycle: the new config becomes pending and is applied at the following boundary, not this one.
- FSM:
  - IDLE->RUN when enable=1; counters start from current cnt values (active_top after reset/apply).
  - RUN->IDLE when enable=0. In the same cycle, cnt<=active_top, and ce_out/frame_sync are forced 0 from the next cycle. The pending config then applies in IDLE.
  - ce_in ignored in IDLE.
- ce_in asserted on consecutive cycles is legal. Each pulse counts.
- No arithmetic overflow: counters only decrement from TOP to 0 and reload.

Test Plan:
- Reset defaults, NS=3, TOP=1,1,1, enable=1, ce_in every cycle -> ce_out[0] every 2nd cycle, [1] every 4th, [2] and frame_sync every 8th. First ce_out[0] 1 cycle after the 2nd ce_in.
- cfg_top={2,0,4} (stage0=4, stage1=0, stage2=2) written mid-frame with ce_in every 3rd cycle -> cfg_ready drops and cfg_pending=1. Old rates persist until frame_sync. Then ce_out[0] every 15 clocks, [1] equal to [0], [2] every 45 clocks. cfg_pending clears at boundary.
- cfg_valid held during the boundary cycle with pend=0 -> accepted, not applied at this boundary. Applied exactly one frame later.
- Second cfg_valid while pending -> cfg_ready=0, no transfer. Original pend_top is applied unchanged.
- enable dropped mid-frame with pending config -> ce_out=0 next cycle. Config applied in IDLE. Re-enable -> first ce_out[0] after new TOP_0+1 ce_in pulses.
- rst asserted mid-RUN with pending config -> all outputs 0, cfg_ready=1, DEFAULT_TOP restored. Pending config is lost.
